// File: rtl/serial_jtag_bridge.sv
// UART-to-JTAG bridge: 8N1 command bytes drive TCK/TMS/TDI with RTCK handshaking,
// and captured TDO bits are packed into bytes that go back out on tx.
module serial_jtag_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int HALF_TCK     = 4,
  parameter int RTCK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  input  logic rtck,
  input  logic tdo,
  output logic tck,
  output logic tms,
  output logic tdi,
  output logic tx,
  output logic busy,
  output logic error
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int TMR_W = $clog2(RTCK_TIMEOUT + HALF_TCK + 1) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_HALF  = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF_TCK - 1);
  localparam logic [TMR_W-1:0] RTCK_LAST = TMR_W'(RTCK_TIMEOUT);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {E_IDLE, E_SETUP, E_HIGH, E_WAIT_HI, E_LOW, E_WAIT_LO, E_SEND} eng_state_t;

  logic [1:0] rst_p;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_p <= 2'b00;
    else          rst_p <= {rst_p[0], 1'b1};
  end
  assign rst_n_int = rst_p[1];

  // stage p0/p1: input synchronizers; rx_p2 is the previous synchronized rx for edge detect
  logic rx_p0, rx_p1, rx_p2, rtck_p0, rtck_p1, tdo_p0, tdo_p1;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      {rx_p0, rx_p1, rx_p2} <= 3'b111;
      {rtck_p0, rtck_p1}    <= 2'b00;
      {tdo_p0, tdo_p1}      <= 2'b00;
    end else begin
      {rx_p0, rx_p1, rx_p2} <= {rx, rx_p0, rx_p1};
      {rtck_p0, rtck_p1}    <= {rtck, rtck_p0};
      {tdo_p0, tdo_p1}      <= {tdo, tdo_p0};
    end
  end

  rx_state_t        r_state;
  logic [BIT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             cmd_full;
  logic [1:0]       cmd_kind;
  logic [2:0]       cmd_arg;
  logic             cmd_done;
  logic             rx_err;
  logic             stop_tick;
  logic             cmd_pending;
  logic             rx_accept;

  // cmd_done lags the engine by a cycle, so a register being released counts as empty
  assign cmd_pending = cmd_full && !cmd_done;
  assign stop_tick   = (r_state == R_STOP) && (r_cnt == BIT_LAST);
  assign rx_accept   = stop_tick && rx_p1 && !cmd_pending;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      cmd_full <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_err <= 1'b0;
      if (cmd_done) cmd_full <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (rx_p2 && !rx_p1) begin
            r_state <= R_START;
            r_cnt   <= '0;
          end
        end
        R_START: begin
          if (r_cnt == BIT_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= rx_p1 ? R_IDLE : R_DATA;
          end else r_cnt <= r_cnt + BIT_W'(1);
        end
        R_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= R_STOP;
          end else r_cnt <= r_cnt + BIT_W'(1);
        end
        R_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_state <= R_IDLE;
            if (!rx_p1 || cmd_pending) rx_err <= 1'b1;
            else                       cmd_full <= 1'b1;
          end else r_cnt <= r_cnt + BIT_W'(1);
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == R_DATA && r_cnt == BIT_LAST) r_shift <= {rx_p1, r_shift[7:1]};
    if (rx_accept) begin
      cmd_kind <= r_shift[7:6];
      cmd_arg  <= r_shift[2:0];
    end
  end

  eng_state_t       e_state;
  logic [TMR_W-1:0] e_tmr;
  logic [2:0]       clk_left;
  logic             cap_en;
  logic [7:0]       cap;
  logic [3:0]       cap_cnt;
  logic [7:0]       snd_byte;
  logic             snd_pend;
  logic             tx_go;
  logic             tx_active;
  logic             rtck_err;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      e_state  <= E_IDLE;
      e_tmr    <= '0;
      clk_left <= '0;
      cap_en   <= 1'b0;
      cap      <= '0;
      cap_cnt  <= '0;
      snd_byte <= '0;
      snd_pend <= 1'b0;
      tx_go    <= 1'b0;
      cmd_done <= 1'b0;
      rtck_err <= 1'b0;
      tck      <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
    end else begin
      tx_go    <= 1'b0;
      cmd_done <= 1'b0;
      rtck_err <= 1'b0;
      case (e_state)
        E_IDLE: begin
          if (cmd_pending) begin
            e_tmr <= '0;
            case (cmd_kind)
              2'b00: begin
                tms      <= cmd_arg[0];
                tdi      <= cmd_arg[1];
                cap_en   <= cmd_arg[2];
                clk_left <= 3'd1;
                e_state  <= E_SETUP;
              end
              2'b01: begin
                tms      <= 1'b1;
                tdi      <= 1'b0;
                cap_en   <= 1'b0;
                clk_left <= 3'd5;
                e_state  <= E_SETUP;
              end
              2'b10: begin
                if (cap_cnt != 4'd0) begin
                  snd_byte <= cap;
                  cap      <= '0;
                  cap_cnt  <= '0;
                  clk_left <= '0;
                  e_state  <= E_SEND;
                end else cmd_done <= 1'b1;
              end
              default: cmd_done <= 1'b1;
            endcase
          end
        end
        E_SETUP: begin
          if (e_tmr == HALF_LAST) begin
            e_tmr   <= '0;
            tck     <= 1'b1;
            e_state <= E_HIGH;
          end else e_tmr <= e_tmr + TMR_W'(1);
        end
        E_HIGH: begin
          if (e_tmr == HALF_LAST) begin
            e_tmr   <= '0;
            e_state <= E_WAIT_HI;
          end else e_tmr <= e_tmr + TMR_W'(1);
        end
        E_WAIT_HI: begin
          // a timeout still takes the tdo sample so the capture stream keeps its length
          if (rtck_p1 || e_tmr == RTCK_LAST) begin
            if (!rtck_p1) rtck_err <= 1'b1;
            e_tmr   <= '0;
            tck     <= 1'b0;
            e_state <= E_LOW;
            if (cap_en) begin
              if (cap_cnt == 4'd7) begin
                snd_byte <= {tdo_p1, cap[6:0]};
                snd_pend <= 1'b1;
                cap      <= '0;
                cap_cnt  <= '0;
              end else begin
                cap[cap_cnt[2:0]] <= tdo_p1;
                cap_cnt           <= cap_cnt + 4'd1;
              end
            end
          end else e_tmr <= e_tmr + TMR_W'(1);
        end
        E_LOW: begin
          if (e_tmr == HALF_LAST) begin
            e_tmr   <= '0;
            e_state <= E_WAIT_LO;
          end else e_tmr <= e_tmr + TMR_W'(1);
        end
        E_WAIT_LO: begin
          if (!rtck_p1 || e_tmr == RTCK_LAST) begin
            if (rtck_p1) rtck_err <= 1'b1;
            e_tmr    <= '0;
            clk_left <= clk_left - 3'd1;
            if (snd_pend)               e_state <= E_SEND;
            else if (clk_left != 3'd1)  e_state <= E_SETUP;
            else begin
              e_state  <= E_IDLE;
              cmd_done <= 1'b1;
            end
          end else e_tmr <= e_tmr + TMR_W'(1);
        end
        E_SEND: begin
          if (!tx_active && !tx_go) begin
            tx_go    <= 1'b1;
            snd_pend <= 1'b0;
            if (clk_left != 3'd0) e_state <= E_SETUP;
            else begin
              e_state  <= E_IDLE;
              cmd_done <= 1'b1;
            end
          end
        end
        default: e_state <= E_IDLE;
      endcase
    end
  end

  logic [8:0]       t_shift;
  logic [3:0]       t_idx;
  logic [BIT_W-1:0] t_cnt;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      tx_active <= 1'b0;
      tx        <= 1'b1;
      t_shift   <= '1;
      t_idx     <= '0;
      t_cnt     <= '0;
    end else if (!tx_active) begin
      tx <= 1'b1;
      if (tx_go) begin
        tx_active <= 1'b1;
        tx        <= 1'b0;
        t_shift   <= {1'b1, snd_byte};
        t_idx     <= '0;
        t_cnt     <= '0;
      end
    end else if (t_cnt == BIT_LAST) begin
      t_cnt <= '0;
      if (t_idx == 4'd9) begin
        tx_active <= 1'b0;
        tx        <= 1'b1;
      end else begin
        tx      <= t_shift[0];
        t_shift <= {1'b1, t_shift[8:1]};
        t_idx   <= t_idx + 4'd1;
      end
    end else t_cnt <= t_cnt + BIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      error <= 1'b0;
      busy  <= 1'b0;
    end else begin
      if (rx_err || rtck_err) error <= 1'b1;
      busy <= (e_state != E_IDLE) || cmd_full || tx_active || tx_go;
    end
  end

endmodule

// File: tb/tb_serial_jtag_bridge.sv
// Bench for serial_jtag_bridge: serial command driver, tx decoder, TCK/TDO scan-chain model
// and a queue-based reference model for randomized command streams.
module tb_serial_jtag_bridge;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic rx = 1'b1;
  logic rtck;
  logic tdo = 1'b0;
  logic tck, tms, tdi, tx, busy, error;
  logic rtck_loop = 1'b1;

  int checks = 0;
  int errors = 0;
  int tck_rises = 0;
  int tck_falls = 0;
  logic [1:0] pin_log[$];
  logic       tdo_q[$];
  logic [7:0] tx_bytes[$];

  assign rtck = rtck_loop ? tck : 1'b0;

  always #5 clk = ~clk;

  serial_jtag_bridge #(.CLKS_PER_BIT(16), .HALF_TCK(4), .RTCK_TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .rtck(rtck), .tdo(tdo),
    .tck(tck), .tms(tms), .tdi(tdi), .tx(tx), .busy(busy), .error(error)
  );

  // Scan chain: log pins at each rising TCK and present the next TDO bit.
  always @(posedge tck) begin
    tck_rises++;
    pin_log.push_back({tms, tdi});
    if (tdo_q.size() > 0) tdo = tdo_q.pop_front();
    else                  tdo = 1'b0;
  end

  always @(negedge tck) tck_falls++;

  // 8N1 decoder for tx.
  always begin
    logic [7:0] b;
    @(negedge tx);
    repeat (8) @(negedge clk);
    if (tx === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = tx;
      end
      repeat (16) @(negedge clk);
      if (tx === 1'b1) tx_bytes.push_back(b);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d", checks);
    $fatal(1);
  end

  task automatic clear_logs();
    tck_rises = 0;
    tck_falls = 0;
    pin_log.delete();
    tdo_q.delete();
    tx_bytes.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rtck_loop = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_logs();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (4) @(negedge clk);
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  function automatic logic [7:0] pack_bits(input logic bits[$]);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < bits.size(); i++) v[i] = bits[i];
    return v;
  endfunction

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tck !== 1'b0)   begin errors++; $display("FAIL reset_tck: got %0b, required 0", tck); end
    checks++; if (tms !== 1'b1)   begin errors++; $display("FAIL reset_tms: got %0b, required 1", tms); end
    checks++; if (tdi !== 1'b0)   begin errors++; $display("FAIL reset_tdi: got %0b, required 0", tdi); end
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %0b, required 1", tx); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b, required 0", error); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_logs();
  endtask

  task automatic test_clock();
    do_reset();
    send_byte(8'h03);
    wait_idle("clock");
    checks++; if (tck_rises != 1) begin errors++; $display("FAIL clock_pulses: got %0d, required 1", tck_rises); end
    checks++; if (tck_falls != 1) begin errors++; $display("FAIL clock_falls: got %0d, required 1", tck_falls); end
    checks++; if (tms !== 1'b1 || tdi !== 1'b1) begin errors++; $display("FAIL clock_pins: tms/tdi got %0b%0b, required 11", tms, tdi); end
    checks++; if (tx_bytes.size() != 0) begin errors++; $display("FAIL clock_tx: got %0d bytes, required 0", tx_bytes.size()); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL clock_error: got %0b, required 0", error); end
  endtask

  task automatic test_capture();
    logic pat[$] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic rnd[$];
    logic [7:0] exp_b;
    do_reset();
    for (int i = 0; i < 8; i++) tdo_q.push_back(pat[i]);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h04);
      wait_idle("capture");
    end
    checks++; if (tx_bytes.size() != 1) begin errors++; $display("FAIL capture_count: got %0d bytes, required 1", tx_bytes.size()); end
    else begin
      checks++; if (tx_bytes[0] !== 8'h4D) begin errors++; $display("FAIL capture_byte: got %02h, required 4d", tx_bytes[0]); end
    end
    clear_logs();
    for (int i = 0; i < 8; i++) rnd.push_back(1'($urandom_range(0, 1)));
    exp_b = pack_bits(rnd);
    for (int i = 0; i < 8; i++) tdo_q.push_back(rnd[i]);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h04);
      wait_idle("capture_rnd");
    end
    checks++; if (tx_bytes.size() != 1) begin errors++; $display("FAIL capture_rnd_count: got %0d bytes, required 1", tx_bytes.size()); end
    else begin
      checks++; if (tx_bytes[0] !== exp_b) begin errors++; $display("FAIL capture_rnd_byte: got %02h, required %02h", tx_bytes[0], exp_b); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tdo_q.push_back(1'b1);
      send_byte(8'h06);
      wait_idle("flush_cap");
    end
    send_byte(8'h80);
    wait_idle("flush");
    checks++; if (tx_bytes.size() != 1) begin errors++; $display("FAIL flush_count: got %0d bytes, required 1", tx_bytes.size()); end
    else begin
      checks++; if (tx_bytes[0] !== 8'h07) begin errors++; $display("FAIL flush_byte: got %02h, required 07", tx_bytes[0]); end
    end
    send_byte(8'h80);
    wait_idle("flush_empty");
    checks++; if (tx_bytes.size() != 1) begin errors++; $display("FAIL flush_empty: got %0d bytes, required 1", tx_bytes.size()); end
    checks++; if (tck_rises != 3) begin errors++; $display("FAIL flush_pulses: got %0d, required 3", tck_rises); end
  endtask

  task automatic test_tapreset();
    do_reset();
    send_byte(8'h02);
    wait_idle("tap_pre");
    clear_logs();
    send_byte(8'h40);
    wait_idle("tapreset");
    checks++; if (tck_rises != 5) begin errors++; $display("FAIL tap_pulses: got %0d, required 5", tck_rises); end
    for (int i = 0; i < pin_log.size(); i++) begin
      checks++;
      if (pin_log[i] !== 2'b10) begin errors++; $display("FAIL tap_pins[%0d]: tms/tdi got %02b, required 10", i, pin_log[i]); end
    end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL tap_error: got %0b, required 0", error); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h01);
    send_byte(8'h02);
    wait_idle("b2b");
    checks++; if (tck_rises != 2) begin errors++; $display("FAIL b2b_pulses: got %0d, required 2", tck_rises); end
    else begin
      checks++; if (pin_log[0] !== 2'b10 || pin_log[1] !== 2'b01) begin
        errors++; $display("FAIL b2b_order: got %02b,%02b, required 10,01", pin_log[0], pin_log[1]);
      end
    end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL b2b_error: got %0b, required 0", error); end
  endtask

  task automatic test_random();
    int exp_pulses = 0;
    logic [1:0] exp_pins[$];
    logic [7:0] exp_tx[$];
    logic bits[$];
    logic exp_tms = 1'b1;
    logic exp_tdi = 1'b0;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      logic [31:0] r = $urandom;
      int kind = (k == 20) ? 7 : int'($urandom_range(0, 9));
      logic [7:0] b;
      logic t;
      if (kind <= 5) begin
        b = {2'b00, r[5:3], r[2], r[1], r[0]};
        t = 1'($urandom_range(0, 1));
        tdo_q.push_back(t);
        exp_pulses++;
        exp_tms = r[0];
        exp_tdi = r[1];
        exp_pins.push_back({r[0], r[1]});
        if (r[2]) begin
          bits.push_back(t);
          if (bits.size() == 8) begin
            exp_tx.push_back(pack_bits(bits));
            bits.delete();
          end
        end
      end else if (kind == 6) begin
        b = {2'b01, r[5:0]};
        for (int i = 0; i < 5; i++) begin
          tdo_q.push_back(1'($urandom_range(0, 1)));
          exp_pins.push_back(2'b10);
        end
        exp_pulses += 5;
        exp_tms = 1'b1;
        exp_tdi = 1'b0;
      end else if (kind <= 8) begin
        b = {2'b10, r[5:0]};
        if (bits.size() > 0) begin
          exp_tx.push_back(pack_bits(bits));
          bits.delete();
        end
      end else begin
        b = {2'b11, r[5:0]};
      end
      send_byte(b);
      wait_idle("rnd");
    end
    checks++; if (tck_rises != exp_pulses) begin errors++; $display("FAIL rnd_pulses: got %0d, required %0d", tck_rises, exp_pulses); end
    checks++; if (pin_log.size() != exp_pins.size()) begin errors++; $display("FAIL rnd_pin_count: got %0d, required %0d", pin_log.size(), exp_pins.size()); end
    else for (int i = 0; i < exp_pins.size(); i++) begin
      checks++;
      if (pin_log[i] !== exp_pins[i]) begin errors++; $display("FAIL rnd_pins[%0d]: got %02b, required %02b", i, pin_log[i], exp_pins[i]); end
    end
    checks++; if (tx_bytes.size() != exp_tx.size()) begin errors++; $display("FAIL rnd_tx_count: got %0d, required %0d", tx_bytes.size(), exp_tx.size()); end
    else for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if (tx_bytes[i] !== exp_tx[i]) begin errors++; $display("FAIL rnd_tx[%0d]: got %02h, required %02h", i, tx_bytes[i], exp_tx[i]); end
    end
    checks++; if (tms !== exp_tms || tdi !== exp_tdi) begin errors++; $display("FAIL rnd_hold: tms/tdi got %0b%0b, required %0b%0b", tms, tdi, exp_tms, exp_tdi); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rnd_error: got %0b, required 0", error); end
  endtask

  task automatic test_timeout();
    do_reset();
    rtck_loop = 1'b0;
    send_byte(8'h00);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_early: error got %0b, required 0", error); end
    wait_idle("timeout");
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %0b, required 1", error); end
    checks++; if (tck_falls != 1) begin errors++; $display("FAIL timeout_fall: got %0d, required 1", tck_falls); end
    checks++; if (tck !== 1'b0) begin errors++; $display("FAIL timeout_tck: got %0b, required 0", tck); end
    rtck_loop = 1'b1;
  endtask

  task automatic test_framing();
    do_reset();
    send_byte(8'h03, 1'b0);
    repeat (40) @(negedge clk);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL frame_error: got %0b, required 1", error); end
    checks++; if (tck_rises != 0) begin errors++; $display("FAIL frame_tck: got %0d pulses, required 0", tck_rises); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL frame_reset_error: got %0b, required 0", error); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL frame_reset_tx: got %0b, required 1", tx); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_abort();
    int n = 0;
    do_reset();
    tdo_q.push_back(1'b1);
    send_byte(8'h06);
    wait_idle("abort_cap");
    send_byte(8'h80);
    while (tx === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL abort_txstart: tx got %0b, required 0", tx); end
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %0b, required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b, required 0", busy); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    clear_logs();
    send_byte(8'h03);
    wait_idle("abort_after");
    checks++; if (tck_rises != 1) begin errors++; $display("FAIL abort_restart: got %0d pulses, required 1", tck_rises); end
    checks++; if (tx_bytes.size() != 0) begin errors++; $display("FAIL abort_tx_after: got %0d bytes, required 0", tx_bytes.size()); end
  endtask

  initial begin
    test_reset();
    test_clock();
    test_capture();
    test_flush();
    test_tapreset();
    test_back_to_back();
    test_random();
    test_timeout();
    test_framing();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
